branch_condition_unit: RTL and testbench

Consumer side of the 3-bit processor flag register: accepts branch requests from decode, waits until every older flag-setting instruction has written its flags, evaluates the 3-bit condition code against the current flags (with same-cycle write bypass), and returns a registered taken/target result to fetch. Sits between decode, the flag register write port and the PC-select logic.

---
 rtl/branch_condition_unit.sv | 187 ++++++++++++++++++
 tb/tb_branch_condition_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_condition_unit.sv
// branch_condition_unit
// Resolves conditional branches against the 3-bit flag register (Z,V,N).
// Branches wait while older flag-setting instructions are in flight. The
// flag value written in the retiring cycle is bypassed straight into the
// condition check, so the result needs no extra cycle.
module branch_condition_unit #(
  parameter int MAX_PENDING = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  flag_q,
  input  logic        flag_wen,
  input  logic [2:0]  flag_wdata,
  input  logic        flag_set_issue,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_ccc,
  input  logic        br_is_reg,
  input  logic [15:0] br_pc_plus2,
  input  logic [8:0]  br_offset,
  input  logic [15:0] br_reg_target,
  output logic        stall,
  output logic        resolve_valid,
  output logic        resolve_taken,
  output logic [15:0] resolve_target,
  output logic        ovf_err
);

  localparam logic [1:0] CNT_MAX = 2'(MAX_PENDING);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state;
  logic [1:0] cnt;

  // branch operands held while waiting for flags
  logic [2:0]         ccc_p1;
  logic               is_reg_p1;
  logic [15:0]        pc_plus2_p1;
  logic signed [8:0]  offset_p1;
  logic [15:0]        reg_target_p1;

  // condition code against flags {Z,V,N}
  function automatic logic cond_eval(input logic [2:0] ccc, input logic [2:0] flags);
    logic z;
    logic v;
    logic n;
    logic res;
    z = flags[2];
    v = flags[1];
    n = flags[0];
    case (ccc)
      3'b000:  res = ~z;
      3'b001:  res = z;
      3'b010:  res = ~z & ~n;
      3'b011:  res = n;
      3'b100:  res = z | (~z & ~n);
      3'b101:  res = n | z;
      3'b110:  res = v;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  // PC-relative target: word offset scaled to bytes, wraps modulo 2^16
  function automatic logic [15:0] rel_target(input logic [15:0] pc,
                                             input logic signed [8:0] off);
    logic signed [15:0] disp;
    disp = {{6{off[8]}}, off, 1'b0};
    return pc + $unsigned(disp);
  endfunction

  // pending counter with saturation at MAX_PENDING and floor at zero
  function automatic logic [1:0] next_count(input logic [1:0] c,
                                            input logic inc,
                                            input logic dec);
    logic [1:0] res;
    res = c;
    if (inc && !dec) begin
      res = (c == CNT_MAX) ? c : c + 2'd1;
    end else if (dec && !inc) begin
      res = (c == 2'd0) ? c : c - 2'd1;
    end
    return res;
  endfunction

  logic        wen_retire;
  logic [2:0]  older_pending;
  logic [2:0]  eff_pending;
  logic [2:0]  eff_flags;
  logic        accept;
  logic        eval_now;
  logic        eval_wait;
  logic        eval_fire;
  logic [2:0]  sel_ccc;
  logic        sel_is_reg;
  logic [15:0] sel_pc_plus2;
  logic signed [8:0] sel_offset;
  logic [15:0] sel_reg_target;
  logic        taken_p0;
  logic [15:0] target_p0;
  logic        ovf_set;

  // hazard tracking, flag bypass and operand selection for evaluation
  always_comb begin
    wen_retire     = flag_wen && (cnt != 2'd0);
    older_pending  = {1'b0, cnt} - {2'b00, wen_retire};
    eff_pending    = older_pending + {2'b00, flag_set_issue};
    eff_flags      = flag_wen ? flag_wdata : flag_q;
    accept         = (state == IDLE) && br_valid;
    eval_now       = accept && (eff_pending == 3'd0);
    eval_wait      = (state == WAIT) && (older_pending == 3'd0);
    eval_fire      = eval_now || eval_wait;
    ovf_set        = flag_set_issue && !flag_wen && (cnt == CNT_MAX);
    if (state == WAIT) begin
      sel_ccc        = ccc_p1;
      sel_is_reg     = is_reg_p1;
      sel_pc_plus2   = pc_plus2_p1;
      sel_offset     = offset_p1;
      sel_reg_target = reg_target_p1;
    end else begin
      sel_ccc        = br_ccc;
      sel_is_reg     = br_is_reg;
      sel_pc_plus2   = br_pc_plus2;
      sel_offset     = $signed(br_offset);
      sel_reg_target = br_reg_target;
    end
    taken_p0 = cond_eval(sel_ccc, eff_flags);
    if (!taken_p0) begin
      target_p0 = sel_pc_plus2;
    end else if (sel_is_reg) begin
      target_p0 = sel_reg_target;
    end else begin
      target_p0 = rel_target(sel_pc_plus2, sel_offset);
    end
  end

  // control: FSM, pending counter, overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      ovf_err <= 1'b0;
    end else begin
      cnt <= next_count(cnt, flag_set_issue, flag_wen);
      if (ovf_set) begin
        ovf_err <= 1'b1;
      end
      case (state)
        IDLE: if (accept && !eval_now) state <= WAIT;
        WAIT: if (eval_wait) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // capture branch operands when a branch is accepted
  always_ff @(posedge clk) begin
    if (accept) begin
      ccc_p1        <= br_ccc;
      is_reg_p1     <= br_is_reg;
      pc_plus2_p1   <= br_pc_plus2;
      offset_p1     <= $signed(br_offset);
      reg_target_p1 <= br_reg_target;
    end
  end

  // ---- stage p1: registered resolution result ----
  // result registers: pulse valid, hold taken/target between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolve_valid  <= 1'b0;
      resolve_taken  <= 1'b0;
      resolve_target <= 16'h0000;
    end else begin
      resolve_valid <= eval_fire;
      if (eval_fire) begin
        resolve_taken  <= taken_p0;
        resolve_target <= target_p0;
      end
    end
  end

  assign br_ready = (state == IDLE);
  assign stall    = (state == WAIT);

endmodule

// File: tb/tb_branch_condition_unit.sv
// Testbench for branch_condition_unit: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the branch/flag hazard rules.
module tb_branch_condition_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  flag_q;
  logic        flag_wen;
  logic [2:0]  flag_wdata;
  logic        flag_set_issue;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_ccc;
  logic        br_is_reg;
  logic [15:0] br_pc_plus2;
  logic [8:0]  br_offset;
  logic [15:0] br_reg_target;
  logic        stall;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [15:0] resolve_target;
  logic        ovf_err;

  int n_tests = 0;
  int n_fail  = 0;

  branch_condition_unit #(.MAX_PENDING(3)) dut (
    .clk(clk), .rst_n(rst_n), .flag_q(flag_q), .flag_wen(flag_wen),
    .flag_wdata(flag_wdata), .flag_set_issue(flag_set_issue),
    .br_valid(br_valid), .br_ready(br_ready), .br_ccc(br_ccc),
    .br_is_reg(br_is_reg), .br_pc_plus2(br_pc_plus2), .br_offset(br_offset),
    .br_reg_target(br_reg_target), .stall(stall),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_cnt;
  bit  m_wait;
  bit  m_valid;
  bit  m_taken;
  int  m_target;
  bit  m_ovf;
  int  h_ccc, h_pc, h_off, h_reg;
  bit  h_is_reg;

  function automatic bit model_cond(int code, bit z, bit v, bit n);
    case (code)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int model_target(int pc, int off9);
    int s;
    s = (off9 >= 256) ? off9 - 512 : off9;
    return (pc + 2 * s) & 16'hFFFF;
  endfunction

  initial begin : model
    int older, eff, fl, code, pc, off, rg;
    bit z, v, n, isr, tk, fire;
    m_cnt = 0; m_wait = 0; m_valid = 0; m_taken = 0; m_target = 0; m_ovf = 0;
    h_ccc = 0; h_pc = 0; h_off = 0; h_reg = 0; h_is_reg = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = 0; m_wait = 0; m_valid = 0; m_taken = 0; m_target = 0; m_ovf = 0;
      end else begin
        older = m_cnt - ((flag_wen && m_cnt > 0) ? 1 : 0);
        eff   = older + (flag_set_issue ? 1 : 0);
        fl    = flag_wen ? int'(flag_wdata) : int'(flag_q);
        z = fl[2]; v = fl[1]; n = fl[0];
        fire = 0;
        code = 0; pc = 0; off = 0; rg = 0; isr = 0;
        if (!m_wait) begin
          if (br_valid) begin
            if (eff == 0) begin
              fire = 1;
              code = br_ccc; pc = br_pc_plus2; off = br_offset; rg = br_reg_target; isr = br_is_reg;
            end else begin
              m_wait = 1;
              h_ccc = br_ccc; h_pc = br_pc_plus2; h_off = br_offset;
              h_reg = br_reg_target; h_is_reg = br_is_reg;
            end
          end
        end else if (older == 0) begin
          fire = 1; m_wait = 0;
          code = h_ccc; pc = h_pc; off = h_off; rg = h_reg; isr = h_is_reg;
        end
        m_valid = fire;
        if (fire) begin
          tk = model_cond(code, z, v, n);
          m_taken  = tk;
          m_target = !tk ? pc : (isr ? rg : model_target(pc, off));
        end
        if (flag_set_issue && !flag_wen) begin
          if (m_cnt == 3) m_ovf = 1;
          else m_cnt = m_cnt + 1;
        end else if (flag_wen && !flag_set_issue && m_cnt > 0) begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  end

  // compare DUT against the model on every falling edge
  initial begin : compare
    forever begin
      @(negedge clk);
      check("m_valid",  resolve_valid,  m_valid);
      check("m_taken",  resolve_taken,  m_taken);
      check("m_target", resolve_target, m_target);
      check("m_stall",  stall,          m_wait);
      check("m_ready",  br_ready,       !m_wait);
      check("m_ovf",    ovf_err,        m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flag_q = 3'b000; flag_wen = 0; flag_wdata = 3'b000; flag_set_issue = 0;
    br_valid = 0; br_ccc = 3'b000; br_is_reg = 0; br_pc_plus2 = 16'h0000;
    br_offset = 9'h000; br_reg_target = 16'h0000;
  endtask

  task automatic branch(input logic [2:0] ccc, input logic is_reg,
                        input logic [15:0] pc, input logic [8:0] off,
                        input logic [15:0] rg);
    br_valid = 1; br_ccc = ccc; br_is_reg = is_reg; br_pc_plus2 = pc;
    br_offset = off; br_reg_target = rg;
  endtask

  initial begin : stim
    clear_inputs();
    rst_n = 0;
    #1;
    repeat (3) tick();
    check("rst_valid",  resolve_valid,  0);
    check("rst_target", resolve_target, 0);
    check("rst_ovf",    ovf_err,        0);
    check("rst_stall",  stall,          0);
    rst_n = 1;
    tick();
    check("rst_ready", br_ready, 1);

    // always-taken PC-relative with negative offset
    branch(3'b111, 0, 16'h0100, 9'h1FE, 16'h0000);
    tick();
    br_valid = 0;
    check("t1_valid",  resolve_valid,  1);
    check("t1_taken",  resolve_taken,  1);
    check("t1_target", resolve_target, 16'h00FC);
    tick();
    check("t1_pulse", resolve_valid,  0);
    check("t1_hold",  resolve_target, 16'h00FC);

    // back-to-back, Z=1
    flag_q = 3'b100;
    branch(3'b001, 0, 16'h0200, 9'h005, 16'h0000);
    tick();
    check("t2a_taken",  resolve_taken,  1);
    check("t2a_target", resolve_target, 16'h020A);
    check("t2a_stall",  stall,          0);
    br_ccc = 3'b000;
    tick();
    br_valid = 0;
    check("t2b_valid",  resolve_valid,  1);
    check("t2b_taken",  resolve_taken,  0);
    check("t2b_target", resolve_target, 16'h0200);
    check("t2b_stall",  stall,          0);
    tick();

    // two pending setters, branch waits for the second write
    clear_inputs();
    flag_set_issue = 1;
    tick();
    tick();
    flag_set_issue = 0;
    branch(3'b011, 0, 16'h0300, 9'h010, 16'h0000);
    tick();
    br_valid = 0;
    check("t3_stall0", stall,    1);
    check("t3_ready0", br_ready, 0);
    flag_wen = 1; flag_wdata = 3'b001;
    tick();
    check("t3_stall1", stall,         1);
    check("t3_valid1", resolve_valid, 0);
    tick();
    flag_wen = 0;
    check("t3_valid",  resolve_valid,  1);
    check("t3_taken",  resolve_taken,  1);
    check("t3_target", resolve_target, 16'h0320);
    check("t3_stall2", stall,          0);
    tick();

    // simultaneous issue and write at cnt=1
    clear_inputs();
    flag_set_issue = 1;
    tick();
    flag_wen = 1;
    branch(3'b111, 0, 16'h0400, 9'h000, 16'h0000);
    tick();
    clear_inputs();
    check("t4_stall", stall, 1);
    flag_wen = 1;
    tick();
    flag_wen = 0;
    check("t4_valid",  resolve_valid,  1);
    check("t4_target", resolve_target, 16'h0400);
    tick();

    // reset while waiting drops the branch
    flag_set_issue = 1;
    tick();
    flag_set_issue = 0;
    branch(3'b110, 1, 16'h0500, 9'h000, 16'hABCD);
    tick();
    br_valid = 0;
    check("t6_stall", stall, 1);
    rst_n = 0;
    #1;
    check("t6_rvalid",  resolve_valid,  0);
    check("t6_rtarget", resolve_target, 0);
    check("t6_rstall",  stall,          0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_novalid", resolve_valid, 0);
    end
    flag_q = 3'b010;
    branch(3'b110, 1, 16'h0500, 9'h000, 16'hABCD);
    tick();
    br_valid = 0;
    check("t6_valid",  resolve_valid,  1);
    check("t6_taken",  resolve_taken,  1);
    check("t6_target", resolve_target, 16'hABCD);

    // overflow: four issues without write
    clear_inputs();
    flag_set_issue = 1;
    repeat (4) tick();
    flag_set_issue = 0;
    check("t5_ovf", ovf_err, 1);
    flag_wen = 1;
    repeat (3) tick();
    flag_wen = 0;
    tick();
    check("t5_ovf_sticky", ovf_err, 1);
    check("t5_drained", br_ready, 1);

    // randomized traffic
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 0;
        clear_inputs();
        tick();
        rst_n = 1;
      end
      flag_q         = 3'($urandom);
      flag_wen       = ($urandom_range(0, 2) == 0);
      flag_wdata     = 3'($urandom);
      flag_set_issue = (m_cnt < 3) && ($urandom_range(0, 2) == 0);
      br_valid       = $urandom_range(0, 1);
      br_ccc         = 3'($urandom);
      br_is_reg      = $urandom_range(0, 1);
      br_pc_plus2    = 16'($urandom);
      br_offset      = 9'($urandom);
      br_reg_target  = 16'($urandom);
      tick();
    end
    clear_inputs();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
